axi_burst_resp: RTL
===================

# axi_burst_resp

Synthesizable AXI read-burst responder: the slave end of the address channel that `axis_addr`-style address generators drive. It accepts address/length commands, queues them in a small command FIFO, and returns `alen+1` data beats per command with a deterministic, address-derived payload and `rlast` on the final beat. It serves as the memory-side stand-in for simulation and on-chip loopback of the streaming read path.

## Interface
- `AXI_ADDR_WIDTH`, 32, address width in bits.
- `AXI_LEN_WIDTH`, 8, burst length field width; beats per burst = `alen+1`.
- `AXI_DATA_WIDTH`, 64, data width in bits; must be >= `AXI_ADDR_WIDTH + AXI_LEN_WIDTH` and a power of two >= 8.
- `CMD_DEPTH_WIDTH`, 2, log2 of command FIFO depth (default 4 entries).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `axi_aaddr`  in  AXI_ADDR_WIDTH  burst start byte address.
- `axi_alen`  in  AXI_LEN_WIDTH  burst length minus one.
- `axi_avalid`  in  1  command valid.
- `axi_aready`  out  1  command accepted when high with `axi_avalid`.
- `axi_rdata`  out  AXI_DATA_WIDTH  beat payload.
- `axi_rlast`  out  1  final beat of current burst.
- `axi_rvalid`  out  1  beat valid.
- `axi_rready`  in  1  beat consumed when high with `axi_rvalid`.
- `busy`  out  1  high while FIFO non-empty or a burst is in progress.

## Operation
- Command FIFO: `2^CMD_DEPTH_WIDTH` entries of {addr, len}; push on `axi_avalid & axi_aready`; `axi_aready = !full & !rst`, registered-free (combinational from FIFO count).
- Beat engine states: IDLE, BURST.
  - IDLE: FIFO non-empty -> pop head, load `base`, `len`, `beat=0`, go BURST.
  - BURST: `axi_rvalid=1`. On `rvalid & rready`: if `beat==len` -> if FIFO non-empty pop and load next command (stay BURST, no gap), else go IDLE; otherwise `beat<=beat+1`.
- Beat address = `base + beat * (AXI_DATA_WIDTH/8)`, truncated modulo 2^AXI_ADDR_WIDTH (wraps, no error).
- `axi_rdata` = {zero-extended `beat` in the upper `AXI_DATA_WIDTH-AXI_ADDR_WIDTH` bits, beat address in the low `AXI_ADDR_WIDTH` bits}.
- `axi_rlast = axi_rvalid & (beat==len)`; `alen=0` yields one beat with `rlast=1`.
- `rdata/rlast` held stable while `rvalid & !rready`.
- Push and pop in the same cycle are both honoured; count unchanged.
- `busy = !empty | (state==BURST)`.

## Timing
- Reset values: `axi_aready=0` during reset, 1 from the first cycle after; `axi_rvalid=0`, `axi_rlast=0`, `axi_rdata=0`, `busy=0`; FIFO empty, state IDLE.
- Latency: command accepted at edge N (FIFO write), popped at edge N+1, first beat valid in the cycle after edge N+1 (2 edges).
- Throughput: one beat per cycle with `rready` held high, including across burst boundaries when the next command is already queued.
- Full: with all entries queued, `axi_aready=0`; it rises in the cycle after a pop.
- Reset mid-operation: FIFO flushed, in-flight burst dropped, `rvalid` low in the cycle after the reset edge; no partial beats resume.

## Test plan
- Single burst: addr 0x100, alen 3, `rready=1` -> beats low word 0x100, 0x108, 0x110, 0x118, upper beat index 0..3, `rlast` on 4th only, first `rvalid` 2 edges after accept.
- Back-pressure: same burst, `rready` toggled 1,0,1,0 -> each beat held stable while `rready=0`, 4 beats total, no duplicates or drops.
- Back-to-back: commands (0x0, alen 1) then (0x1000, alen 0) queued -> 3 consecutive valid beats 0x0, 0x8, 0x1000, `rlast` on beats 2 and 3, no idle cycle.
- FIFO full: `rready=0`, issue 6 commands -> 4 accepted + 1 in engine, `axi_aready=0` on 6th until first burst completes.
- Wrap: addr 0xFFFFFFF8, alen 1 -> low words 0xFFFFFFF8 then 0x00000000.
- Reset mid-burst: alen 7, assert `rst` after beat 2 -> `rvalid=0`, `busy=0`, `aready=0` during reset; a new command after reset starts at beat 0.

Source files
------------

// File: rtl/axi_burst_resp.sv
// AXI read-burst responder: queues {addr, len} commands and returns len+1 beats
// per command whose payload is {beat index, beat address}.
module axi_burst_resp #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 8,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int CMD_DEPTH_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
  input  logic [AXI_LEN_WIDTH-1:0]  axi_alen,
  input  logic                      axi_avalid,
  output logic                      axi_aready,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic                      axi_rlast,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic                      busy
);

  localparam int DEPTH = 1 << CMD_DEPTH_WIDTH;
  localparam int CMD_W = AXI_ADDR_WIDTH + AXI_LEN_WIDTH;
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);
  localparam logic [CMD_DEPTH_WIDTH:0]  FULL_CNT   = (CMD_DEPTH_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                     state;
  logic [CMD_W-1:0]           cmd_mem [DEPTH];
  logic [CMD_DEPTH_WIDTH-1:0] wr_ptr;
  logic [CMD_DEPTH_WIDTH-1:0] rd_ptr;
  logic [CMD_DEPTH_WIDTH:0]   count;
  logic                       empty;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       beat_done;
  logic [AXI_ADDR_WIDTH-1:0]  head_addr;
  logic [AXI_LEN_WIDTH-1:0]   head_len;
  logic [AXI_ADDR_WIDTH-1:0]  addr;
  logic [AXI_LEN_WIDTH-1:0]   len;
  logic [AXI_LEN_WIDTH-1:0]   beat;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign axi_aready = !full && !rst;
  assign push       = axi_avalid && axi_aready;
  assign head_addr  = cmd_mem[rd_ptr][AXI_ADDR_WIDTH-1:0];
  assign head_len   = cmd_mem[rd_ptr][CMD_W-1:AXI_ADDR_WIDTH];

  // The last beat of a burst hands straight over to a queued command, so no bubble.
  assign beat_done  = (state == BURST) && axi_rready && (beat == len);
  assign pop        = !empty && ((state == IDLE) || beat_done);

  always_ff @(posedge clk) begin
    if (push) cmd_mem[wr_ptr] <= {axi_alen, axi_aaddr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Beat address advances incrementally and wraps modulo 2^AXI_ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            addr  <= head_addr;
            len   <= head_len;
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (axi_rready) begin
            if (beat == len) begin
              if (pop) begin
                addr <= head_addr;
                len  <= head_len;
                beat <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              beat <= beat + 1'b1;
              addr <= addr + BEAT_BYTES;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi_rvalid = (state == BURST);
  assign axi_rlast  = axi_rvalid && (beat == len);
  assign busy       = !empty || (state == BURST);

  always_comb begin
    axi_rdata = '0;
    if (axi_rvalid) begin
      axi_rdata[AXI_ADDR_WIDTH-1:0]              = addr;
      axi_rdata[AXI_ADDR_WIDTH +: AXI_LEN_WIDTH] = beat;
    end
  end

endmodule
